// File: rtl/adc_scan_sched_if.sv
// Result hand-off channel of the ADC scan scheduler: one tagged conversion
// result presented with valid/ready, plus the overwrite (drop) pulse.
interface adc_scan_sched_if;
    // Transfer happens on a rising clock edge where oVALID and iREADY are both high;
    // oCH/oDATA stay stable while oVALID is high until the next publish.
    logic        oVALID;
    logic        iREADY;
    logic [2:0]  oCH;
    logic [11:0] oDATA;
    logic        oDROP;

    modport master (output oVALID, oCH, oDATA, oDROP, input iREADY);
    modport slave  (input oVALID, oCH, oDATA, oDROP, output iREADY);
endinterface

// File: rtl/adc_scan_sched.sv
// Round-robin scan controller for an 8-channel 16-SCLK serial ADC; results are
// tagged with the channel addressed one frame earlier and held in a 1-entry buffer.
module adc_scan_sched #(
    parameter int CLK_DIV  = 4,
    parameter int IDLE_GAP = 16
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iEN,
    input  logic [7:0] iCH_MASK,
    output logic       oCS_n,
    output logic       oSCLK,
    output logic       oDIN,
    input  logic       iDOUT,
    output logic       oBUSY,
    output logic [1:0] oSTATE,
    adc_scan_sched_if.master res
);
    typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, SHIFT = 2'd2, GAP = 2'd3} state_t;

    localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);
    localparam logic [15:0] GAP_M1 = 16'(IDLE_GAP - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  bit_q, bit_d;
    logic        half_q, half_d;
    logic        cs_n_q, cs_n_d;
    logic        sclk_q, sclk_d;
    logic        din_q, din_d;
    logic [11:0] shift_q, shift_d;
    logic        prime_q, prime_d;
    logic [2:0]  last_q, last_d;
    logic [2:0]  tag_q, tag_d;
    logic        vld_q, vld_d;
    logic [2:0]  ch_q, ch_d;
    logic [11:0] data_q, data_d;
    logic        drop_q, drop_d;

    logic [2:0]  nxt;
    logic [2:0]  idx;
    logic        start;
    logic [3:0]  nbit;

    // Lowest set mask bit strictly above last_q, wrapping; falls back to last_q itself.
    always_comb begin
        nxt = last_q;
        idx = 3'd0;
        for (int i = 8; i >= 1; i--) begin
            idx = last_q + 3'(i);
            if (iCH_MASK[idx]) nxt = idx;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        half_d  = half_q;
        cs_n_d  = cs_n_q;
        sclk_d  = sclk_q;
        din_d   = din_q;
        shift_d = shift_q;
        prime_d = prime_q;
        last_d  = last_q;
        tag_d   = tag_q;
        vld_d   = vld_q & ~res.iREADY;
        ch_d    = ch_q;
        data_d  = data_q;
        drop_d  = 1'b0;
        start   = iEN & (|iCH_MASK);
        nbit    = bit_q + 4'd1;

        case (state_q)
            IDLE: begin
                cs_n_d = 1'b1;
                sclk_d = 1'b1;
                if (start) begin
                    state_d = SETUP;
                    cs_n_d  = 1'b0;
                    cnt_d   = 16'd0;
                    prime_d = 1'b1;
                    tag_d   = last_q;
                    last_d  = nxt;
                end
            end
            SETUP: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == DIV_M1) begin
                    state_d = SHIFT;
                    cnt_d   = 16'd0;
                    bit_d   = 4'd0;
                    half_d  = 1'b0;
                    sclk_d  = 1'b0;
                    din_d   = 1'b0;
                end
            end
            SHIFT: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == DIV_M1) begin
                    cnt_d = 16'd0;
                    if (!half_q) begin
                        half_d = 1'b1;
                        sclk_d = 1'b1;
                        if (bit_q >= 4'd4) shift_d = {shift_q[10:0], iDOUT};
                    end else if (bit_q == 4'd15) begin
                        state_d = GAP;
                        cs_n_d  = 1'b1;
                        sclk_d  = 1'b1;
                        // The first frame after a start returns a stale conversion.
                        if (prime_q) begin
                            prime_d = 1'b0;
                        end else begin
                            vld_d  = 1'b1;
                            data_d = shift_q;
                            ch_d   = tag_q;
                            drop_d = vld_q & ~res.iREADY;
                        end
                    end else begin
                        bit_d  = nbit;
                        half_d = 1'b0;
                        sclk_d = 1'b0;
                        case (nbit)
                            4'd2:    din_d = last_q[2];
                            4'd3:    din_d = last_q[1];
                            4'd4:    din_d = last_q[0];
                            default: din_d = 1'b0;
                        endcase
                    end
                end
            end
            GAP: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == GAP_M1) begin
                    cnt_d = 16'd0;
                    if (start) begin
                        state_d = SETUP;
                        cs_n_d  = 1'b0;
                        tag_d   = last_q;
                        last_d  = nxt;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_q <= IDLE;
            cnt_q   <= 16'd0;
            bit_q   <= 4'd0;
            half_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b1;
            din_q   <= 1'b0;
            shift_q <= 12'd0;
            prime_q <= 1'b0;
            last_q  <= 3'd7;
            tag_q   <= 3'd0;
            vld_q   <= 1'b0;
            ch_q    <= 3'd0;
            data_q  <= 12'd0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            half_q  <= half_d;
            cs_n_q  <= cs_n_d;
            sclk_q  <= sclk_d;
            din_q   <= din_d;
            shift_q <= shift_d;
            prime_q <= prime_d;
            last_q  <= last_d;
            tag_q   <= tag_d;
            vld_q   <= vld_d;
            ch_q    <= ch_d;
            data_q  <= data_d;
            drop_q  <= drop_d;
        end
    end

    assign oCS_n      = cs_n_q;
    assign oSCLK      = sclk_q;
    assign oDIN       = din_q;
    assign oBUSY      = (state_q != IDLE);
    assign oSTATE     = state_q;
    assign res.oVALID = vld_q;
    assign res.oCH    = ch_q;
    assign res.oDATA  = data_q;
    assign res.oDROP  = drop_q;
endmodule

// File: tb/tb_adc_scan_sched.sv
// Bench for adc_scan_sched: an ADC pin model answering 12'h100+channel, a
// scoreboard of tagged results, a mask table and hand-written corner sequences.
module tb_adc_scan_sched;
    logic       iCLK = 1'b0;
    logic       iRST;
    logic       iEN;
    logic [7:0] iCH_MASK;
    logic       oCS_n, oSCLK, oDIN, oBUSY;
    logic       iDOUT = 1'b0;
    logic [1:0] oSTATE;

    adc_scan_sched_if ifc();

    adc_scan_sched #(.CLK_DIV(4), .IDLE_GAP(16)) dut (
        .iCLK(iCLK), .iRST(iRST), .iEN(iEN), .iCH_MASK(iCH_MASK),
        .oCS_n(oCS_n), .oSCLK(oSCLK), .oDIN(oDIN), .iDOUT(iDOUT),
        .oBUSY(oBUSY), .oSTATE(oSTATE), .res(ifc)
    );

    always #5 iCLK = ~iCLK;

    int errors = 0;
    int checks = 0;

    logic [14:0] exp_q[$];
    logic [2:0]  din_log[$];

    // ADC model / pin monitor state
    int          cyc = 0;
    int          hi_cnt = 1000;
    int          last_hi = 0;
    int          cs_fall_t = 0;
    int          period_t = 0;
    int          last_fall_t = 0;
    int          setup_t = 0;
    int          pulses = 0;
    int          nfall = 0;
    int          rk = 0;
    int          nfr = 0;
    int          xfers = 0;
    int          dropcnt = 0;
    logic        period_bad = 1'b0;
    logic        prev_cs = 1'b1;
    logic        prev_sclk = 1'b1;
    logic        frame_prime = 1'b1;
    logic [2:0]  addr_reg = 3'd0;
    logic [2:0]  new_addr = 3'd0;
    logic [2:0]  frame_tag = 3'd0;
    logic [11:0] frame_data = 12'd0;
    logic [2:0]  last_xfer_ch = 3'd0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] din_at(input int i);
        return (i < din_log.size()) ? 32'(din_log[i]) : 32'hFF;
    endfunction

    // ADC behaviour: DOUT changes on SCLK falls, DIN captured on rises k=2..4.
    always @(negedge iCLK) begin
        cyc++;
        if (!iRST) begin
            prev_cs   = 1'b1;
            prev_sclk = 1'b1;
            hi_cnt    = 1000;
        end else begin
            if (prev_cs && !oCS_n) begin
                frame_prime = (hi_cnt != 16);
                period_t    = cyc - cs_fall_t;
                cs_fall_t   = cyc;
                last_hi     = hi_cnt;
                hi_cnt      = 0;
                frame_tag   = addr_reg;
                frame_data  = 12'h100 + 12'(addr_reg);
                nfall       = 0;
                rk          = 0;
                period_bad  = 1'b0;
                nfr++;
            end
            if (!oCS_n && prev_sclk && !oSCLK) begin
                if (nfall == 0) setup_t = cyc - cs_fall_t;
                else if (cyc - last_fall_t != 8) period_bad = 1'b1;
                last_fall_t = cyc;
                iDOUT = (nfall >= 4) ? frame_data[15 - nfall] : 1'b0;
                nfall++;
            end
            if (!oCS_n && !prev_sclk && oSCLK) begin
                if (rk >= 2 && rk <= 4) new_addr = {new_addr[1:0], oDIN};
                rk++;
            end
            if (!prev_cs && oCS_n) begin
                pulses = nfall;
                if (rk == 16) begin
                    din_log.push_back(new_addr);
                    if (!frame_prime) exp_q.push_back({frame_tag, frame_data});
                    addr_reg = new_addr;
                end
            end
            if (oCS_n && hi_cnt < 1000) hi_cnt++;
            if (ifc.oDROP) begin
                dropcnt++;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            if (ifc.oVALID && ifc.iREADY) begin
                xfers++;
                last_xfer_ch = ifc.oCH;
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 32'({ifc.oCH, ifc.oDATA}), 32'h7FFF_FFFF);
                end else begin
                    check("result", 32'({ifc.oCH, ifc.oDATA}), 32'(exp_q.pop_front()));
                end
            end
            prev_cs   = oCS_n;
            prev_sclk = oSCLK;
        end
    end

    task automatic do_reset();
        iRST = 1'b0;
        repeat (2) @(posedge iCLK);
        #1;
        exp_q.delete();
        din_log.delete();
        dropcnt = 0;
        xfers   = 0;
        iRST    = 1'b1;
    endtask

    task automatic wait_falls(input int n);
        int target;
        int budget;
        target = nfr + n;
        budget = 400 * n;
        while (nfr < target && budget > 0) begin
            @(negedge iCLK); #1;
            budget--;
        end
        if (nfr < target) check("wait_frames_timeout", 32'(nfr), 32'(target));
    endtask

    task automatic wait_rk(input int k);
        int budget;
        budget = 400;
        while (rk < k && budget > 0) begin
            @(negedge iCLK); #1;
            budget--;
        end
        if (rk < k) check("wait_bit_timeout", 32'(rk), 32'(k));
    endtask

    typedef struct {
        logic [7:0] mask;
        logic [2:0] a0;
        logic [2:0] a1;
        logic [2:0] a2;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int budget;
        tbl[0] = '{mask: 8'h05, a0: 3'd0, a1: 3'd2, a2: 3'd0};
        tbl[1] = '{mask: 8'h80, a0: 3'd7, a1: 3'd7, a2: 3'd7};
        tbl[2] = '{mask: 8'h92, a0: 3'd1, a1: 3'd4, a2: 3'd7};
        tbl[3] = '{mask: 8'h01, a0: 3'd0, a1: 3'd0, a2: 3'd0};
        tbl[4] = '{mask: 8'hC0, a0: 3'd6, a1: 3'd7, a2: 3'd6};

        iRST = 1'b0; iEN = 1'b0; iCH_MASK = 8'h00; ifc.iREADY = 1'b1;
        repeat (3) @(posedge iCLK);
        #1;
        check("rst_cs_n",  32'(oCS_n), 32'd1);
        check("rst_sclk",  32'(oSCLK), 32'd1);
        check("rst_din",   32'(oDIN), 32'd0);
        check("rst_valid", 32'(ifc.oVALID), 32'd0);
        check("rst_ch",    32'(ifc.oCH), 32'd0);
        check("rst_data",  32'(ifc.oDATA), 32'd0);
        check("rst_drop",  32'(ifc.oDROP), 32'd0);
        check("rst_busy",  32'(oBUSY), 32'd0);
        iRST = 1'b1;

        // Enabled with an empty mask stays idle; a single-bit mask then scans ch7
        iEN = 1'b1;
        repeat (20) @(posedge iCLK);
        #1;
        check("mask0_busy", 32'(oBUSY), 32'd0);
        check("mask0_cs_n", 32'(oCS_n), 32'd1);
        iCH_MASK = 8'h80;
        wait_falls(3);
        check("mask80_xfers", 32'(xfers), 32'd1);
        check("mask80_ch",    32'(last_xfer_ch), 32'd7);

        // Mask table: address order and pin timing for continuous scanning
        for (int i = 0; i < 5; i++) begin
            iEN = 1'b0;
            do_reset();
            iCH_MASK = tbl[i].mask;
            ifc.iREADY = 1'b1;
            iEN = 1'b1;
            wait_falls(4);
            check("addr0", din_at(0), 32'(tbl[i].a0));
            check("addr1", din_at(1), 32'(tbl[i].a1));
            check("addr2", din_at(2), 32'(tbl[i].a2));
            check("cs_to_sclk", 32'(setup_t), 32'd4);
            check("sclk_period_bad", 32'(period_bad), 32'd0);
            check("sclk_pulses", 32'(pulses), 32'd16);
            check("cs_high_gap", 32'(last_hi), 32'd16);
            check("frame_period", 32'(period_t), 32'd148);
        end

        // Enable dropped mid-frame: frame finishes, publishes, then idles; restart re-primes
        iEN = 1'b0;
        do_reset();
        iCH_MASK = 8'h05;
        ifc.iREADY = 1'b1;
        iEN = 1'b1;
        wait_falls(2);
        wait_rk(8);
        iEN = 1'b0;
        budget = 400;
        while (oBUSY && budget > 0) begin
            @(negedge iCLK); #1;
            budget--;
        end
        check("en_drop_busy", 32'(oBUSY), 32'd0);
        check("en_drop_cs_n", 32'(oCS_n), 32'd1);
        check("en_drop_xfers", 32'(xfers), 32'd1);
        iEN = 1'b1;
        wait_falls(2);
        check("reprime_xfers", 32'(xfers), 32'd1);
        check("reprime_addr", din_at(2), 32'd0);

        // Consumer stalled: second publish overwrites the first
        iEN = 1'b0;
        do_reset();
        iCH_MASK = 8'h05;
        ifc.iREADY = 1'b0;
        iEN = 1'b1;
        wait_falls(4);
        check("drop_count", 32'(dropcnt), 32'd1);
        check("drop_valid", 32'(ifc.oVALID), 32'd1);
        check("drop_data",  32'(ifc.oDATA), 32'h102);
        check("drop_ch",    32'(ifc.oCH), 32'd2);

        // Reset in the middle of a channel-0 frame, then restart from the lowest bit
        wait_falls(1);
        wait_rk(10);
        #1;
        iRST = 1'b0;
        #1;
        check("midrst_cs_n",  32'(oCS_n), 32'd1);
        check("midrst_sclk",  32'(oSCLK), 32'd1);
        check("midrst_valid", 32'(ifc.oVALID), 32'd0);
        do_reset();
        ifc.iREADY = 1'b1;
        wait_falls(2);
        check("midrst_restart_addr", din_at(0), 32'd0);

        iEN = 1'b0;
        repeat (4) @(posedge iCLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/adc_scan_sched.md
# adc_scan_sched

Round-robin scan controller for the 8-channel serial ADC (ADC128S022-style: 16-SCLK frame, 3-bit address on DIN, 12-bit result on DOUT). It owns the ADC SPI pins, sequences conversions over the channels enabled in a mask, and tags each result with its channel. Results are handed to a downstream consumer, such as the LCD formatter or LED driver, through a one-entry valid/ready buffer. It replaces free-running single-channel capture with a shared, scheduled converter.

## Interface
Parameters:
- CLK_DIV, 4: iCLK cycles per SCLK half-period (≥2).
- IDLE_GAP, 16: iCLK cycles CS_n is held high between frames (≥1).

Ports:
- iCLK  in  1  system clock; all logic on rising edge.
- iRST  in  1  reset, asynchronous, active-low.
- iEN  in  1  scan enable.
- iCH_MASK  in  8  channel enable mask, bit n = channel n.
- oCS_n  out  1  ADC chip select, active-low.
- oSCLK  out  1  ADC serial clock, idles high.
- oDIN  out  1  ADC address serial data.
- iDOUT  in  1  ADC serial data.
- oVALID  out  1  result available.
- iREADY  in  1  consumer accepts result.
- oCH  out  3  channel of the presented result.
- oDATA  out  12  presented result, unsigned.
- oDROP  out  1  one-cycle pulse: unread result overwritten.
- oBUSY  out  1  high whenever state ≠ IDLE.

## Operation
- States: IDLE, SETUP, SHIFT, GAP.
- IDLE: oCS_n=1, oSCLK=1. When iEN=1 and iCH_MASK≠0:
  - select the next channel;
  - set the prime flag;
  - go to SETUP.
- Channel select: lowest set mask bit strictly above the last-addressed channel, wrapping 7→0. After reset, "last" = 7, so the first pick is the lowest set bit. iCH_MASK is sampled only at selection time.
- SETUP: oCS_n=0, oSCLK=1 for CLK_DIV cycles, then SHIFT.
- SHIFT: 16 SCLK periods, k=0..15. Each period is CLK_DIV cycles low, then CLK_DIV cycles high.
- oDIN is updated at each SCLK falling edge:
  - k=2 → ch[2]; k=3 → ch[1]; k=4 → ch[0];
  - otherwise 0.
- iDOUT is sampled on the iCLK cycle of each SCLK rising edge for k=4..15, into bits 11..0 (MSB first).
- After the k=15 high half, go to GAP: oCS_n=1, oSCLK=1.
- Result tagging: the ADC returns the channel addressed in the previous frame. The result is tagged with the prior address. When the prime flag is set, the result is discarded and the flag cleared.
- Publish on GAP entry if not discarded. oDATA/oCH are loaded and oVALID=1.
- Publish while oVALID=1 and iREADY=0: the buffer is overwritten and oDROP pulses.
- Publish with iREADY=1 in the same cycle: the old entry is consumed, the new one loaded, and there is no drop.
- End of GAP (IDLE_GAP cycles):
  - if iEN=1 and mask≠0: select the next channel, go to SETUP;
  - else go to IDLE. The prime flag is set on the next start.
- iEN falling or mask changing mid-frame: the current frame and GAP complete normally.
- Handshake: transfer when oVALID&iREADY on a rising edge. oVALID clears next cycle unless a new publish occurs. oDATA/oCH are stable while oVALID=1 and no publish occurs.

## Timing
- Reset values: oCS_n=1, oSCLK=1, oDIN=0, oVALID=0, oCH=0, oDATA=0, oDROP=0, oBUSY=0. Internal counters and the prime flag are cleared; last channel = 7.
- Reset asserted mid-frame: outputs are forced to reset values immediately (asynchronously). The partial frame is abandoned.
- IDLE→SETUP: one cycle after iEN=1 with mask≠0 is sampled.
- Frame period = (1+32)·CLK_DIV + IDLE_GAP cycles; 148 at the defaults.
- oVALID rises on the first GAP cycle, i.e. the cycle after the k=15 high half ends.
- Single-bit mask: the same channel is repeated every frame.

## Test plan
- Mask 8'b0000_0101, iEN=1, ADC model returns 12'h100+ch:
  - DIN addresses go 0,2,0,2…;
  - results are ch0=0x100 and ch2=0x102, correctly tagged;
  - the first frame produces no oVALID.
- iREADY held 0, two results published → oDROP pulses once; oDATA holds the second result.
- Mask=0 with iEN=1 → remains IDLE; oCS_n=1, oBUSY=0. Setting the mask to 8'h80 → frames start, and the first valid result is ch7.
- iEN dropped during SHIFT k=8 → frame completes and the result is published, then IDLE. Re-enabling → a new priming frame occurs (no oVALID for its result).
- iRST low during SHIFT k=10 → oCS_n=1, oSCLK=1, oVALID=0 immediately. After release with iEN=1, scanning restarts from the lowest set bit.
- Pin timing, defaults: CS_n falls 4 cycles before the first SCLK fall; SCLK period 8 cycles; 16 pulses; CS_n high for 16 cycles between frames.
